// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised valid/ready pipeline-stage register with a
// 2-entry skid buffer. in_ready is a flop output, so downstream back-pressure
// never reaches upstream combinationally. A flush turns every held entry into
// a bubble; control outputs are forced to zero whenever out_valid is low.
// Optional perf counters (stall_cnt, bubble_cnt) are built only when the
// macro PIPE_STAGE_PERF_EN is defined; otherwise both ports are tied to zero.
//
//   state   | meaning
//   --------+-------------------------------------------
//   S_EMPTY | main invalid, skid invalid
//   S_BUSY  | main valid (drives out_*), skid invalid
//   S_FULL  | main valid, skid valid, in_ready low
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic                w_acc;
    logic                w_pop;
    logic                w_out_valid;
    logic                w_ld_main_in;
    logic                w_ld_main_skid;
    logic                w_ld_skid;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_acc       = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
    assign out_data  = r_main_data;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_EMPTY;
        else         r_state <= w_state_nxt;
    end

    // Next state and register-load selects; flush overrides every transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt  = S_BUSY;
                        w_ld_main_in = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_acc && w_pop) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = S_FULL;
                        w_ld_skid   = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        w_state_nxt    = S_BUSY;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // in_ready registered from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_in_ready <= 1'b1;
        else         r_in_ready <= (w_state_nxt != S_FULL);
    end

    // Main and skid payload registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_ld_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters, cleared by flush.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (!w_out_valid && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios followed by random traffic,
// all checked against a queue-based model of a 2-deep FIFO stage with a
// registered ready (ready next cycle iff fewer than two entries are held).
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [15:0] c;
        logic [31:0] d;
    } ent_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_ctrl;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    ent_t q[$];
    logic m_ready = 1'b1;
    int   m_stall = 0;
    int   m_bubble = 0;
    int   m_stall4 = 0;
    int   m_bubble4 = 0;

    always #5 clock = ~clock;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

`ifdef PIPE_STAGE_PERF_EN
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_ctrl;
    logic [31:0] s_out_data;
    logic [3:0]  stall4, bubble4;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut4 (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .stall_cnt(stall4), .bubble_cnt(bubble4)
    );
`endif

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ready   = 1'b1;
        m_stall   = 0;
        m_bubble  = 0;
        m_stall4  = 0;
        m_bubble4 = 0;
    endtask

    task automatic check_outputs();
        chk_eq("in_ready", in_ready, m_ready);
        chk_eq("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk_eq("out_ctrl", out_ctrl, q[0].c);
            chk_eq("out_data", out_data, q[0].d);
        end else begin
            chk_eq("out_ctrl_bubble", out_ctrl, 16'h0);
        end
`ifdef PIPE_STAGE_PERF_EN
        chk_eq("stall_cnt", stall_cnt, m_stall);
        chk_eq("bubble_cnt", bubble_cnt, m_bubble);
        chk_eq("stall_cnt4", stall4, m_stall4);
        chk_eq("bubble_cnt4", bubble4, m_bubble4);
`else
        chk_eq("stall_cnt_off", stall_cnt, 16'h0);
        chk_eq("bubble_cnt_off", bubble_cnt, 16'h0);
`endif
    endtask

    // Drive one cycle of inputs, advance the model at the rising edge,
    // then check at the following falling edge.
    task automatic cycle(input logic v, input logic [15:0] c, input logic [31:0] d,
                         input logic ordy, input logic fl);
        logic acc, pop, valid;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        valid = (q.size() != 0);
        acc   = v && m_ready;
        pop   = valid && ordy;
        @(posedge clock);
        if (fl) begin
            q.delete();
            m_stall = 0; m_bubble = 0; m_stall4 = 0; m_bubble4 = 0;
        end else begin
            if (valid && !ordy) begin
                m_stall  = sat_inc(m_stall, 65535);
                m_stall4 = sat_inc(m_stall4, 15);
            end
            if (!valid) begin
                m_bubble  = sat_inc(m_bubble, 65535);
                m_bubble4 = sat_inc(m_bubble4, 15);
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{c: c, d: d});
        end
        m_ready = (q.size() < 2);
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        // Reset held with an upstream entry presented.
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 16'hFFFF;
        in_data  = 32'h12345678;
        repeat (2) @(negedge clock);
        chk_eq("rst_out_valid", out_valid, 1'b0);
        chk_eq("rst_out_ctrl", out_ctrl, 16'h0);
        chk_eq("rst_out_data", out_data, 32'h0);
        chk_eq("rst_in_ready", in_ready, 1'b1);
        resetn = 1'b1;
        model_reset();

        cycle(1'b1, 16'h00FF, 32'hAAAAAAAA, 1'b0, 1'b0);
        chk_eq("first_data", out_data, 32'hAAAAAAAA);
        chk_eq("first_ctrl", out_ctrl, 16'h00FF);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // Streaming: 8 back-to-back entries with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'(i + 1), 32'(i), 1'b1, 1'b0);
            chk_eq("stream_data", out_data, 32'(i));
            chk_eq("stream_ready", in_ready, 1'b1);
        end
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure into the skid register.
        cycle(1'b1, 16'h0A0A, 32'h55555555, 1'b0, 1'b0);
        cycle(1'b1, 16'h0B0B, 32'hF0F0F0F0, 1'b0, 1'b0);
        chk_eq("skid_ready_low", in_ready, 1'b0);
        chk_eq("skid_hold_a", out_data, 32'h55555555);
        cycle(1'b1, 16'h0C0C, 32'hDEADBEEF, 1'b0, 1'b0);
        chk_eq("skid_hold_a2", out_data, 32'h55555555);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        chk_eq("skid_emit_b", out_data, 32'hF0F0F0F0);
        chk_eq("skid_ready_back", in_ready, 1'b1);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        chk_eq("skid_drained", out_valid, 1'b0);

        // Flush while FULL with a new entry offered.
        cycle(1'b1, 16'h1111, 32'h11111111, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 32'h22222222, 1'b0, 1'b0);
        cycle(1'b1, 16'hCCCC, 32'hCCCCCCCC, 1'b0, 1'b1);
        chk_eq("flush_valid", out_valid, 1'b0);
        chk_eq("flush_ctrl", out_ctrl, 16'h0);
        chk_eq("flush_ready", in_ready, 1'b1);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        chk_eq("flush_no_c", out_valid, 1'b0);

        // Asynchronous reset between edges while stalled in FULL.
        cycle(1'b1, 16'h3333, 32'h33333333, 1'b0, 1'b0);
        cycle(1'b1, 16'h4444, 32'h44444444, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk_eq("async_valid", out_valid, 1'b0);
        chk_eq("async_ctrl", out_ctrl, 16'h0);
        chk_eq("async_data", out_data, 32'h0);
        chk_eq("async_ready", in_ready, 1'b1);
        #1 resetn = 1'b1;
        model_reset();
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        // Stall 5 cycles, drain, idle 3 cycles.
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 16'h5555, 32'h5, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        chk_eq("perf_stall5", stall_cnt, 16'd5);
        chk_eq("perf_bubble", bubble_cnt, 16'd4);
        // 4-bit counter saturation.
        cycle(1'b1, 16'h6666, 32'h6, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        chk_eq("perf_sat4", stall4, 4'hF);
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
        chk_eq("perf_flush_clr", stall_cnt, 16'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  16'($urandom), $urandom,
                  1'($urandom_range(0, 99) < 65),
                  1'($urandom_range(0, 99) < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
